// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch and data ports.
// Data wins contention until MAX_STREAK consecutive data grants starve a pending fetch.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_ready_q, d_ready_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          settle_s;
  logic          grant_d_s;
  logic          grant_f_s;

  // Next-state, grant selection and streak bookkeeping
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    // While a ready pulse is out the retiring requester still shows its old
    // request, so that cycle grants nothing and requests are re-evaluated next.
    settle_s    = if_ready_q | d_ready_q;
    grant_d_s   = d_req & (~if_req | (streak_q != STREAK_MAX));
    grant_f_s   = if_req & ~grant_d_s;
    case (state_q)
      IDLE: begin
        if (!settle_s && grant_d_s) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            streak_d = {SW{1'b0}};
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (!settle_s && grant_f_s) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DW{1'b0}};
          streak_d    = {SW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata;
        end else begin
          state_d = FETCH;
        end
      end
      DATA: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, streak and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= {SW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      if_ready_q  <= 1'b0;
      if_rdata_q  <= {DW{1'b0}};
      d_ready_q   <= 1'b0;
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: randomized requesters and memory, a reference
// memory image for read data, and a rule-level model of the grant priority and streak.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
  localparam int MAXS = 4;
  localparam logic [31:0] IF_BASE = 32'h0040_0000;
  localparam logic [31:0] D_BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [31:0] dmem [16];
  logic [31:0] ref_dmem [16];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];
  byte         grant_log [$];
  int          if_ready_cyc = 0;
  int          d_ready_cyc = 0;
  bit          mem_en = 1'b1;
  int          force_lat = -1;

  function automatic logic [31:0] imem_word(input logic [3:0] k);
    return 32'h2002_000A + {12'h000, k, 16'h0000};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_ready(input bit is_d, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_ready : if_ready) && n < 200);
    if (!(is_d ? d_ready : if_ready)) begin
      checks++;
      $display("FAIL %s_timeout: no ready after %0d cycles, required a ready pulse", name, n);
    end
  endtask

  // Caller is at posedge+#1; returns at posedge+#1 after the ready cycle.
  task automatic do_fetch(input int k);
    if_addr = IF_BASE + 32'(k) * 32'd4;
    if_req  = 1'b1;
    if_q.push_back(imem_word(4'(k)));
    wait_ready(1'b0, "fetch");
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input int j, input logic [31:0] wd);
    d_we    = we;
    d_addr  = D_BASE + 32'(j) * 32'd4;
    d_wdata = wd;
    d_req   = 1'b1;
    if (we) ref_dmem[j] = wd;
    else last_rd = ref_dmem[j];
    d_q.push_back(last_rd);
    wait_ready(1'b1, "data");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic fetch_stream(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      do_fetch(int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic data_stream(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      do_data(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom());
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
  endtask

  // Memory device: variable latency (0 = ack in first mem_req cycle), checks field stability.
  initial begin : mem_model
    bit          active;
    int          wait_c;
    logic [64:0] snap;
    active = 1'b0;
    wait_c = -1;
    snap   = 65'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_en) begin
        mem_ack = 1'b0;
        if (!rst || !mem_req) begin
          active = 1'b0;
        end else begin
          if (!active) begin
            active = 1'b1;
            snap   = {mem_we, mem_addr, mem_wdata};
            wait_c = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          end else begin
            check("mem_fields_stable", 128'({mem_we, mem_addr, mem_wdata}), 128'(snap));
          end
          if (wait_c == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr[28] ? dmem[mem_addr[5:2]] : imem_word(mem_addr[5:2]);
            if (mem_we) dmem[mem_addr[5:2]] = mem_wdata;
          end else begin
            mem_rdata = $urandom();
          end
          if (wait_c >= 0) wait_c--;
        end
      end
    end
  end

  // Monitor: scoreboard pops on ready pulses; grant priority checked on each mem_req rise.
  initial begin : monitor
    logic prev_if, prev_d, prev_mreq;
    int   streak_m;
    bit   is_d, exp_d;
    prev_if = 1'b0; prev_d = 1'b0; prev_mreq = 1'b0; streak_m = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_if = 1'b0; prev_d = 1'b0; prev_mreq = 1'b0; streak_m = 0;
      end else begin
        if (if_ready) begin
          if_ready_cyc = cyc;
          if (if_q.size() == 0) check("if_ready_unexpected", 128'(if_ready), 128'(1'b0));
          else check("if_rdata", 128'(if_rdata), 128'(if_q.pop_front()));
        end
        if (d_ready) begin
          d_ready_cyc = cyc;
          if (d_q.size() == 0) check("d_ready_unexpected", 128'(d_ready), 128'(1'b0));
          else check("d_rdata", 128'(d_rdata), 128'(d_q.pop_front()));
        end
        if (mem_req && !prev_mreq) begin
          is_d = mem_addr[28];
          grant_log.push_back(is_d ? 8'h44 : 8'h46);
          if (!prev_if && !prev_d) begin
            check("grant_without_request", 128'({prev_if, prev_d}), 128'(2'b11));
          end else begin
            if (prev_if && prev_d) exp_d = (streak_m < MAXS);
            else exp_d = prev_d;
            check("grant_port_is_data", 128'(is_d), 128'(exp_d));
          end
          if (is_d && prev_if) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
          else streak_m = 0;
        end
        prev_if   = if_req;
        prev_d    = d_req;
        prev_mreq = mem_req;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin : stimulus
    string exp4;
    for (int j = 0; j < 16; j++) begin
      dmem[j]     = 32'h11 + 32'(j) * 32'h0101_0101;
      ref_dmem[j] = dmem[j];
    end
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 128'({mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, d_ready, d_rdata}), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, 1-cycle memory: ready two cycles after the request cycle.
    force_lat = 0;
    if_addr = IF_BASE;
    if_req  = 1'b1;
    if_q.push_back(32'h2002_000A);
    @(negedge clk);
    check("t1_cycle_n_idle", 128'({mem_req, if_ready}), 128'(2'b00));
    @(negedge clk);
    check("t1_cycle_n1_mem", 128'({mem_req, mem_we, mem_addr, if_ready}), 128'({1'b1, 1'b0, IF_BASE, 1'b0}));
    @(negedge clk);
    check("t1_cycle_n2_ready", 128'(if_ready), 128'(1'b1));
    @(posedge clk); #1;
    if_req = 1'b0;

    // Data write with a 3-cycle mem_req window; d_rdata must keep its value.
    force_lat = 2;
    d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    ref_dmem[1] = 32'hDEAD_BEEF;
    d_q.push_back(last_rd);
    @(negedge clk);
    @(negedge clk);
    check("t2_mem_write_fields", 128'({mem_req, mem_we, mem_addr, mem_wdata}),
          128'({1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF}));
    wait_ready(1'b1, "t2");
    @(posedge clk); #1;
    d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Simultaneous requests: data first, fetch ready at least 2 cycles later.
    force_lat = -1;
    fork
      do_fetch(3);
      do_data(1'b0, 1, 32'h0);
    join
    check("t3_data_before_fetch_gap2", 128'((if_ready_cyc - d_ready_cyc) >= 2), 128'(1'b1));

    // Continuous data traffic with fetch pending: streak forces every fifth grant to fetch.
    grant_log.delete();
    fork
      for (int i = 0; i < 2; i++) do_fetch(i + 8);
      for (int i = 0; i < 10; i++) do_data(1'($urandom_range(0, 1)), i, $urandom());
    join
    exp4 = "DDDDFDDDDFDD";
    check("t4_grant_count", 128'(grant_log.size()), 128'(exp4.len()));
    for (int i = 0; i < exp4.len() && i < grant_log.size(); i++)
      check("t4_grant_order", 128'(grant_log[i]), 128'(exp4[i]));

    // Reset mid data access: outputs clear at once and no ready ever appears.
    force_lat = 20;
    d_we = 1'b0; d_addr = D_BASE + 32'd8; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_access_in_flight", 128'(mem_req), 128'(1'b1));
    #2 rst = 1'b0;
    #1;
    check("t5_async_reset_outputs", 128'({mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, d_ready, d_rdata}), 128'(0));
    d_req = 1'b0;
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    force_lat = -1;
    repeat (4) @(posedge clk);
    #1;
    do_fetch(5);

    // Spurious ack while idle: nothing happens, and the next fetch still works.
    mem_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_after_stray_ack", 128'({mem_req, if_ready, d_ready}), 128'(3'b000));
    end
    mem_en = 1'b1;
    @(posedge clk); #1;
    do_fetch(7);

    // Randomized concurrent traffic.
    fork
      fetch_stream(40, 3);
      data_stream(60, 3);
    join

    repeat (5) @(negedge clk);
    check("if_queue_drained", 128'(if_q.size()), 128'(0));
    check("d_queue_drained", 128'(d_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
